// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: fixed-slot VGA scan-out reads (one per 4x4 block column)
// interleaved with a one-entry buffered host write port.
module vga_fb_arbiter #(
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 783,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_END   = 514,
  parameter int unsigned FB_W        = 160,
  parameter int unsigned FB_H        = 120,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned PIX_W       = 12
) (
  input  logic              clk_25M,
  input  logic              rst_n,
  input  logic [15:0]       h_count,
  input  logic [15:0]       v_count,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [PIX_W-1:0]  host_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  output logic              frame_start,
  output logic              addr_err
);

  localparam logic [15:0] H_START    = 16'(H_ACT_START);
  localparam logic [15:0] H_END      = 16'(H_ACT_END);
  localparam logic [15:0] V_START    = 16'(V_ACT_START);
  localparam logic [15:0] V_END      = 16'(V_ACT_END);
  localparam logic [15:0] SLOT_FIRST = 16'(H_ACT_START - 2);
  localparam logic [15:0] SLOT_LAST  = 16'(H_ACT_START - 2 + 4 * (FB_W - 1));
  localparam logic [1:0]  V_PHASE    = 2'(V_ACT_START);
  localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);
  localparam int unsigned COL_W = $clog2(FB_W);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FB_W - 1);

  typedef enum logic [1:0] {S_BLANK, S_FETCH, S_LINE_END} state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic                buf_full_q, buf_full_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [PIX_W-1:0]    buf_data_q, buf_data_d;
  logic                rd_pend_q, rd_pend_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic                frame_q, frame_d;
  logic                err_q, err_d;

  logic                vact, hact, slot, drain_now, accept, addr_ok;
  logic [15:0]         h_off;
  logic [1:0]          v_phase;
  logic [ADDR_W-1:0]   slot_addr;

  // Display slots are decoded from the counters alone, so reads resume mid-line after reset.
  assign vact      = (v_count >= V_START) && (v_count <= V_END);
  assign hact      = (h_count >= H_START) && (h_count <= H_END);
  assign h_off     = h_count - SLOT_FIRST;
  assign slot      = vact && (h_count >= SLOT_FIRST) && (h_count <= SLOT_LAST) && (h_off[1:0] == 2'd0);
  assign slot_addr = row_base_q + ADDR_W'(h_off >> 2);
  assign v_phase   = v_count[1:0] - V_PHASE;

  assign addr_ok    = host_addr < FB_SIZE;
  assign drain_now  = rst_n && buf_full_q && !slot;
  assign host_ready = rst_n && (!buf_full_q || drain_now);
  assign accept     = host_valid && host_ready;

  assign mem_en    = rst_n && (slot || drain_now);
  assign mem_we    = drain_now;
  assign mem_addr  = drain_now ? buf_addr_q : slot_addr;
  assign mem_wdata = buf_data_q;

  assign pix_valid   = rst_n && hact && vact;
  assign pix_out     = pix_valid ? pix_q : '0;
  assign frame_start = rst_n && frame_q;
  assign addr_err    = rst_n && err_q;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    case (state_q)
      S_BLANK: begin
        col_d = '0;
        if (vact && (h_count == SLOT_FIRST)) begin
          state_d = S_FETCH;
          col_d   = COL_W'(1);
        end
      end
      S_FETCH: begin
        if (!vact) begin
          state_d = S_BLANK;
        end else if (slot) begin
          if (col_q == LAST_COL) state_d = S_LINE_END;
          else                   col_d   = col_q + COL_W'(1);
        end
      end
      S_LINE_END: begin
        state_d = S_BLANK;
        col_d   = '0;
        // Each stored row covers four display lines.
        if (v_phase == 2'd3) row_base_d = row_base_q + FB_W_A;
      end
      default: begin
        state_d = S_BLANK;
        col_d   = '0;
      end
    endcase
    if (!vact) row_base_d = '0;
  end

  always_comb begin
    buf_full_d = buf_full_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    if (drain_now) buf_full_d = 1'b0;
    // A same-cycle accept refills the slot being drained.
    if (accept && addr_ok) begin
      buf_full_d = 1'b1;
      buf_addr_d = host_addr;
      buf_data_d = host_data;
    end
    err_d     = err_q || (accept && !addr_ok);
    rd_pend_d = slot;
    pix_d     = rd_pend_q ? mem_rdata : pix_q;
    frame_d   = (h_count == 16'd0) && (v_count == 16'd0);
  end

  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      state_q    <= S_BLANK;
      col_q      <= '0;
      row_base_q <= '0;
      buf_full_q <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      rd_pend_q  <= 1'b0;
      pix_q      <= '0;
      frame_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      buf_full_q <= buf_full_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      rd_pend_q  <= rd_pend_d;
      pix_q      <= pix_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: counters driven directly, behavioural single-port RAM
// whose unwritten words read back as their own address.
module tb_vga_fb_arbiter;

  logic        clk_25M = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] h_count = '0;
  logic [15:0] v_count = '0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [14:0] host_addr = '0;
  logic [11:0] host_data = '0;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = '0;
  logic [11:0] pix_out;
  logic        pix_valid, frame_start, addr_err;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  vga_fb_arbiter dut (
    .clk_25M(clk_25M), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr), .host_data(host_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_out(pix_out), .pix_valid(pix_valid),
    .frame_start(frame_start), .addr_err(addr_err)
  );

  always #5 clk_25M = ~clk_25M;
  always @(posedge clk_25M) cyc <= cyc + 1;

  logic [11:0] ram    [0:32767];
  bit          wr_vld [0:32767];
  always @(posedge clk_25M) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        wr_vld[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= wr_vld[mem_addr] ? ram[mem_addr] : 12'(mem_addr);
      end
    end
  end

  // Inputs change 1 time unit after the edge; outputs are sampled on the falling edge.
  task automatic step(input int h, input int v, input bit rst, input bit hv, input int ha, input int hd);
    @(posedge clk_25M);
    #1;
    rst_n      = rst;
    h_count    = 16'(h);
    v_count    = 16'(v);
    host_valid = hv;
    host_addr  = 15'(ha);
    host_data  = 12'(hd);
    @(negedge clk_25M);
  endtask

  task automatic fast_line(input int v, input bit chk, input int base);
    for (int k = 0; k < 160; k++) begin
      step(142 + 4 * k, v, 1'b1, 1'b0, 0, 0);
      if (chk) begin
        n_checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 15'(base + k)})
          $display("FAIL slot_read v=%0d k=%0d: got en=%b we=%b addr=%0d, want en=1 we=0 addr=%0d",
                   v, k, mem_en, mem_we, mem_addr, base + k);
        else n_pass++;
      end
    end
    step(779, v, 1'b1, 1'b0, 0, 0);
    step(780, v, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(302, 100, 1'b0, 1'b1, 5, 7);
      n_checks++;
      if ({mem_en, mem_we, host_ready, pix_valid, frame_start, addr_err, pix_out} !== '0)
        $display("FAIL reset_outputs cycle %0d: got en=%b we=%b rdy=%b pv=%b fs=%b err=%b pix=%0d, want all 0",
                 i, mem_en, mem_we, host_ready, pix_valid, frame_start, addr_err, pix_out);
      else n_pass++;
    end
    $display("test_reset: done");
  endtask

  task automatic test_frame_pulse();
    int hs[6] = '{798, 799, 0, 1, 2, 0};
    int vs[6] = '{524, 524, 0, 0, 0, 1};
    bit exp[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(hs[i], vs[i], 1'b1, 1'b0, 0, 0);
      n_checks++;
      if (frame_start !== exp[i])
        $display("FAIL frame_start at h=%0d v=%0d: got %b, want %b", hs[i], vs[i], frame_start, exp[i]);
      else n_pass++;
    end
    step(3, 1, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if (frame_start !== 1'b0) $display("FAIL frame_start_after h=3 v=1: got %b, want 0", frame_start);
    else n_pass++;
    $display("test_frame_pulse: done");
  endtask

  task automatic test_scanout();
    bit          slot, ev;
    logic [11:0] ep;
    for (int v = 35; v <= 38; v++) fast_line(v, 1'b1, 0);
    for (int h = 0; h < 800; h++) begin
      step(h, 39, 1'b1, 1'b0, 0, 0);
      slot = (h >= 142) && (h <= 778) && ((h - 142) % 4 == 0);
      n_checks++;
      if (slot) begin
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 15'(160 + (h - 142) / 4)})
          $display("FAIL scan_read h=%0d: got en=%b we=%b addr=%0d, want en=1 we=0 addr=%0d",
                   h, mem_en, mem_we, mem_addr, 160 + (h - 142) / 4);
        else n_pass++;
      end else begin
        if (mem_en !== 1'b0) $display("FAIL scan_idle h=%0d: got en=%b, want 0", h, mem_en);
        else n_pass++;
      end
      ev = (h >= 144) && (h <= 783);
      ep = ev ? 12'(160 + (h - 144) / 4) : 12'd0;
      n_checks++;
      if ({pix_valid, pix_out} !== {ev, ep})
        $display("FAIL scan_pix h=%0d: got valid=%b pix=%0d, want valid=%b pix=%0d", h, pix_valid, pix_out, ev, ep);
      else n_pass++;
    end
    $display("test_scanout: done");
  endtask

  task automatic test_row_advance();
    for (int v = 42; v <= 510; v += 4) fast_line(v, 1'b0, 0);
    fast_line(514, 1'b1, 19040);
    for (int h = 140; h < 148; h++) begin
      step(h, 515, 1'b1, 1'b0, 0, 0);
      n_checks++;
      if (mem_en !== 1'b0) $display("FAIL v515_idle h=%0d: got en=%b, want 0", h, mem_en);
      else n_pass++;
    end
    fast_line(35, 1'b1, 0);
    $display("test_row_advance: done");
  endtask

  task automatic test_host_collision();
    int qa[$];
    int qd[$];
    int qc[$];
    int next_a = 0;
    bit full = 1'b0;
    bit slot, hv, acc;
    int h, v, lat;
    for (int t = 0; t < 803; t++) begin
      h  = t % 800;
      v  = (t < 800) ? 36 : 37;
      hv = (t < 800);
      step(h, v, 1'b1, hv, next_a, (next_a * 3 + 5) % 4096);
      slot = (v == 36) && (h >= 142) && (h <= 778) && ((h - 142) % 4 == 0);
      if (slot) begin
        n_checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 15'((h - 142) / 4)})
          $display("FAIL coll_slot h=%0d: got en=%b we=%b addr=%0d, want en=1 we=0 addr=%0d",
                   h, mem_en, mem_we, mem_addr, (h - 142) / 4);
        else n_pass++;
      end
      n_checks++;
      if (host_ready !== !(full && slot))
        $display("FAIL coll_ready h=%0d: got %b, want %b", h, host_ready, !(full && slot));
      else n_pass++;
      if (mem_we === 1'b1) begin
        n_checks++;
        if (qa.size() == 0) begin
          $display("FAIL coll_write h=%0d: got write addr=%0d with nothing accepted, want no write", h, mem_addr);
        end else begin
          lat = cyc - qc[0];
          if (mem_addr !== 15'(qa[0]) || mem_wdata !== 12'(qd[0]) || lat < 1 || lat > 2)
            $display("FAIL coll_write h=%0d: got addr=%0d data=%0d lat=%0d, want addr=%0d data=%0d lat 1..2",
                     h, mem_addr, mem_wdata, lat, qa[0], qd[0]);
          else n_pass++;
          $display("write addr=%0d data=%0d lat=%0d", mem_addr, mem_wdata, lat);
          void'(qa.pop_front());
          void'(qd.pop_front());
          void'(qc.pop_front());
        end
      end
      acc = hv && host_ready;
      if (acc) begin
        qa.push_back(next_a);
        qd.push_back((next_a * 3 + 5) % 4096);
        qc.push_back(cyc);
        next_a++;
      end
      full = acc || (full && slot);
    end
    n_checks++;
    if (qa.size() != 0) $display("FAIL coll_drain: got %0d writes never issued, want 0", qa.size());
    else n_pass++;
    $display("test_host_collision: done, %0d writes accepted", next_a);
  endtask

  task automatic test_addr_err();
    step(10, 10, 1'b1, 1'b1, 19199, 321);
    n_checks++;
    if ({host_ready, addr_err} !== 2'b10) $display("FAIL err_last_ok: got rdy=%b err=%b, want rdy=1 err=0", host_ready, addr_err);
    else n_pass++;
    step(11, 10, 1'b1, 1'b1, 19200, 4095);
    n_checks++;
    if ({host_ready, mem_we, mem_addr, mem_wdata, addr_err} !== {1'b1, 1'b1, 15'd19199, 12'd321, 1'b0})
      $display("FAIL err_boundary_write: got rdy=%b we=%b addr=%0d data=%0d err=%b, want rdy=1 we=1 addr=19199 data=321 err=0",
               host_ready, mem_we, mem_addr, mem_wdata, addr_err);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(12 + i, 10, 1'b1, 1'b0, 0, 0);
      n_checks++;
      if ({mem_en, mem_we, addr_err} !== 3'b001)
        $display("FAIL err_sticky cycle %0d: got en=%b we=%b err=%b, want en=0 we=0 err=1", i, mem_en, mem_we, addr_err);
      else n_pass++;
    end
    $display("test_addr_err: done");
  endtask

  task automatic test_reset_midline();
    for (int h = 290; h < 300; h++) step(h, 100, 1'b1, 1'b1, 5000 + h, h);
    for (int i = 0; i < 3; i++) begin
      step(300, 100, 1'b0, 1'b0, 0, 0);
      n_checks++;
      if ({mem_en, mem_we, host_ready, pix_valid, frame_start, addr_err, pix_out} !== '0)
        $display("FAIL midreset_outputs cycle %0d: got en=%b we=%b rdy=%b pv=%b fs=%b err=%b pix=%0d, want all 0",
                 i, mem_en, mem_we, host_ready, pix_valid, frame_start, addr_err, pix_out);
      else n_pass++;
    end
    step(301, 100, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if (mem_en !== 1'b0) $display("FAIL midreset_dropped h=301: got en=%b we=%b, want en=0", mem_en, mem_we);
    else n_pass++;
    step(302, 100, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 15'd40})
      $display("FAIL midreset_read h=302: got en=%b we=%b addr=%0d, want en=1 we=0 addr=40", mem_en, mem_we, mem_addr);
    else n_pass++;
    step(303, 100, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if (mem_en !== 1'b0) $display("FAIL midreset_idle h=303: got en=%b, want 0", mem_en);
    else n_pass++;
    step(304, 100, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if ({pix_valid, pix_out, addr_err} !== {1'b1, 12'd125, 1'b0})
      $display("FAIL midreset_pix h=304: got valid=%b pix=%0d err=%b, want valid=1 pix=125 err=0",
               pix_valid, pix_out, addr_err);
    else n_pass++;
    $display("test_reset_midline: done");
  endtask

  initial begin
    test_reset();
    test_frame_pulse();
    test_scanout();
    test_row_advance();
    test_host_collision();
    test_addr_err();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
